// File: rtl/fp_pkg.sv
// ============================================================================
//  Module      : fp_pkg
//  Description : Shared fixed-point helpers for the widening/narrowing
//                datapath blocks. Integer-bit derivation and the
//                saturation max/min bit patterns for a given total width.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fp_pkg;

    // Widest format the saturation helpers can describe.
    localparam int C_FP_MAX_W = 64;

    // Integer bits (sign included) of an S(nb,nbf) format.
    function automatic int nbi(input int nb, input int nbf);
        return nb - nbf;
    endfunction

    // Largest positive value at width nb: 0 followed by all 1s.
    // The pattern sits in the low nb bits; callers size-cast to nb.
    function automatic logic [C_FP_MAX_W-1:0] sat_max(input int nb);
        return (C_FP_MAX_W'(1) << (nb - 1)) - C_FP_MAX_W'(1);
    endfunction

    // Most negative value at width nb: 1 followed by all 0s.
    function automatic logic [C_FP_MAX_W-1:0] sat_min(input int nb);
        return C_FP_MAX_W'(1) << (nb - 1);
    endfunction

endpackage : fp_pkg

`default_nettype wire

// File: rtl/fp_sat_add.sv
// ============================================================================
//  Module      : fp_sat_add
//  Description : Combinational two's-complement saturating adder.
//                The sum is formed one bit wider than the operands; when the
//                two top bits of that sum disagree the result is clamped to
//                the most positive / most negative value and ovf is raised.
//  Ports       : a, b  - signed NB-bit operands
//                sum   - saturated NB-bit result
//                ovf   - 1 when the true sum did not fit in NB bits
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_sat_add
    import fp_pkg::*;
#(
    parameter int NB = 32
) (
    input  logic [NB-1:0] a,
    input  logic [NB-1:0] b,
    output logic [NB-1:0] sum,
    output logic          ovf
);

    localparam logic [NB-1:0] c_SAT_MAX = NB'(sat_max(NB));
    localparam logic [NB-1:0] c_SAT_MIN = NB'(sat_min(NB));

    logic [NB:0] w_full;

    always_comb begin
        w_full = {a[NB-1], a} + {b[NB-1], b};
        ovf    = w_full[NB] ^ w_full[NB-1];
        if (ovf) begin
            // The extra top bit carries the true sign of the overflowed sum.
            sum = w_full[NB] ? c_SAT_MIN : c_SAT_MAX;
        end else begin
            sum = w_full[NB-1:0];
        end
    end

endmodule : fp_sat_add

`default_nettype wire

// File: rtl/fp_extend_accum.sv
// ============================================================================
//  Module      : fp_extend_accum
//  Description : Streaming fixed-point widener plus integrate-and-dump
//                accumulator. Each accepted S(NB_IN,NBF_IN) sample is aligned
//                exactly into S(NB_OUT,NBF_OUT), N_ACC samples are summed with
//                saturation, and the frame sum is presented on a
//                valid/ready output register.
//  Ports       : i_clk, i_rst_n      - clock, async active-low reset
//                i_valid/o_ready     - input sample handshake, i_data sample
//                i_clear             - synchronous abort of the current frame
//                o_valid/i_ready     - output result handshake
//                o_data, o_sat       - frame sum and its saturation flag
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_extend_accum
    import fp_pkg::*;
#(
    parameter int NB_IN   = 16,
    parameter int NBF_IN  = 15,
    parameter int NB_OUT  = 32,
    parameter int NBF_OUT = 30,
    parameter int N_ACC   = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    input  logic [NB_IN-1:0]  i_data,
    output logic              o_ready,
    input  logic              i_clear,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [NB_OUT-1:0] o_data,
    output logic              o_sat
);

    localparam int c_NBI_IN  = nbi(NB_IN, NBF_IN);
    localparam int c_NBI_OUT = nbi(NB_OUT, NBF_OUT);
    localparam int c_EXT_LO  = NBF_OUT - NBF_IN;
    localparam int c_CW      = (N_ACC > 1) ? $clog2(N_ACC) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(N_ACC - 1);

    // ------------------------------------------------------------------
    // Parameter legality: the wide format must contain the narrow one.
    // ------------------------------------------------------------------
    if ((NBF_OUT < NBF_IN) || (c_NBI_OUT < c_NBI_IN) || (N_ACC < 1)) begin : g_cfg_error
        $error("fp_extend_accum: illegal parameter set");
    end

    logic [NB_OUT-1:0] r_acc;
    logic [c_CW-1:0]   r_cnt;
    logic              r_sat_st;

    logic [NB_OUT-1:0] w_ext;
    logic [NB_OUT-1:0] w_sum;
    logic              w_ovf;
    logic              w_last;
    logic              w_accept;
    logic              w_dump;
    logic              w_out_hs;

    // Sign-extending to the full width and then shifting left places the
    // binary point exactly: the high side receives (NBI_OUT-NBI_IN) sign
    // copies and the low side (NBF_OUT-NBF_IN) zeros.
    assign w_ext = NB_OUT'($signed(i_data)) << c_EXT_LO;

    fp_sat_add #(
        .NB (NB_OUT)
    ) u_sat_add (
        .a   (r_acc),
        .b   (w_ext),
        .sum (w_sum),
        .ovf (w_ovf)
    );

    assign w_last   = (r_cnt == c_LAST);
    assign w_out_hs = o_valid & i_ready;

    // Only the frame-closing sample has to wait for a pending result to
    // drain; the rest of the next frame keeps streaming in.
    assign o_ready  = ~i_clear & ~(o_valid & ~i_ready & w_last);
    assign w_accept = i_valid & o_ready;
    assign w_dump   = w_accept & w_last;

    // ------------------------------------------------------------------
    // Accumulator, sample counter and sticky saturation flag
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc    <= '0;
            r_cnt    <= '0;
            r_sat_st <= 1'b0;
        end else if (i_clear) begin
            r_acc    <= '0;
            r_cnt    <= '0;
            r_sat_st <= 1'b0;
        end else if (w_accept) begin
            if (w_last) begin
                r_acc    <= '0;
                r_cnt    <= '0;
                r_sat_st <= 1'b0;
            end else begin
                r_acc    <= w_sum;
                r_cnt    <= r_cnt + c_CW'(1);
                r_sat_st <= r_sat_st | w_ovf;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output register: a dump in the same cycle as a handshake reloads it
    // directly, so back-to-back results need no bubble.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_data  <= '0;
            o_sat   <= 1'b0;
            o_valid <= 1'b0;
        end else if (w_dump) begin
            o_data  <= w_sum;
            o_sat   <= r_sat_st | w_ovf;
            o_valid <= 1'b1;
        end else if (w_out_hs) begin
            o_valid <= 1'b0;
        end
    end

endmodule : fp_extend_accum

`default_nettype wire

// File: tb/tb_fp_extend_accum.sv
// ============================================================================
//  Module      : tb_fp_extend_accum
//  Description : Self-checking bench for fp_extend_accum. Two instances are
//                used: one with N_ACC=1 (pure extension) and one with
//                N_ACC=4 (frame accumulation, backpressure, clear, reset).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fp_extend_accum;

    logic clk;
    logic rst_n;

    // N_ACC = 1 instance
    logic        v1, rdy_out1, vo1, sat1;
    logic [15:0] d1;
    logic [31:0] q1;

    // N_ACC = 4 instance
    logic        v4, rdy_out4, clr4, vo4, rdy_in4, sat4;
    logic [15:0] d4;
    logic [31:0] q4;

    int checks;
    int errors;

    fp_extend_accum #(
        .NB_IN(16), .NBF_IN(15), .NB_OUT(32), .NBF_OUT(30), .N_ACC(1)
    ) dut1 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_valid (v1),
        .i_data  (d1),
        .o_ready (rdy_out1),
        .i_clear (1'b0),
        .o_valid (vo1),
        .i_ready (1'b1),
        .o_data  (q1),
        .o_sat   (sat1)
    );

    fp_extend_accum #(
        .NB_IN(16), .NBF_IN(15), .NB_OUT(32), .NBF_OUT(30), .N_ACC(4)
    ) dut4 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_valid (v4),
        .i_data  (d4),
        .o_ready (rdy_out4),
        .i_clear (clr4),
        .o_valid (vo4),
        .i_ready (rdy_in4),
        .o_data  (q4),
        .o_sat   (sat4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One sample into the N_ACC=1 instance; returns just after the edge.
    task automatic push1(input logic [15:0] s);
        @(negedge clk);
        v1 = 1'b1;
        d1 = s;
        #1;
        check("push1_ready", {31'd0, rdy_out1}, 32'd1);
        @(posedge clk);
        #1;
        v1 = 1'b0;
    endtask

    // One sample into the N_ACC=4 instance, waiting (bounded) for o_ready.
    task automatic push4(input logic [15:0] s);
        int k;
        @(negedge clk);
        v4 = 1'b1;
        d4 = s;
        #1;
        k = 0;
        while (!rdy_out4 && k < 20) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (!rdy_out4) check("push4_ready_timeout", {31'd0, rdy_out4}, 32'd1);
        @(posedge clk);
        #1;
        v4 = 1'b0;
    endtask

    typedef struct {
        int          sel;      // 1 or 4: which instance / frame length
        logic [15:0] smp;      // sample value (repeated sel times)
        logic [31:0] exp_data;
        logic        exp_sat;
    } vec_t;

    vec_t tbl[10];

    initial begin
        checks  = 0;
        errors  = 0;
        v1 = 1'b0; d1 = '0;
        v4 = 1'b0; d4 = '0; clr4 = 1'b0; rdy_in4 = 1'b1;

        tbl[0] = '{1, 16'h8001, 32'hC0008000, 1'b0};
        tbl[1] = '{1, 16'h7FFF, 32'h3FFF8000, 1'b0};
        tbl[2] = '{1, 16'hFFFF, 32'hFFFF8000, 1'b0};
        tbl[3] = '{1, 16'h0000, 32'h00000000, 1'b0};
        tbl[4] = '{4, 16'h2000, 32'h40000000, 1'b0};
        tbl[5] = '{4, 16'h4000, 32'h7FFFFFFF, 1'b1};
        tbl[6] = '{4, 16'h8000, 32'h80000000, 1'b1};
        tbl[7] = '{4, 16'h0000, 32'h00000000, 1'b0};
        tbl[8] = '{4, 16'hF000, 32'hE0000000, 1'b0};
        tbl[9] = '{4, 16'h8000, 32'h80000000, 1'b1};

        // ---------------- reset state ----------------
        rst_n = 1'b0;
        #12;
        check("rst_valid4", {31'd0, vo4}, 32'd0);
        check("rst_data4", q4, 32'h0);
        check("rst_valid1", {31'd0, vo1}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_ready4", {31'd0, rdy_out4}, 32'd1);

        // ---------------- table-driven frames ----------------
        for (int i = 0; i < 10; i++) begin
            if (tbl[i].sel == 1) begin
                push1(tbl[i].smp);
                check($sformatf("t%0d_valid", i), {31'd0, vo1}, 32'd1);
                check($sformatf("t%0d_data", i), q1, tbl[i].exp_data);
                check($sformatf("t%0d_sat", i), {31'd0, sat1}, {31'd0, tbl[i].exp_sat});
            end else begin
                for (int j = 0; j < 4; j++) begin
                    push4(tbl[i].smp);
                    if (j == 2) check($sformatf("t%0d_early_valid", i), {31'd0, vo4}, 32'd0);
                end
                check($sformatf("t%0d_valid", i), {31'd0, vo4}, 32'd1);
                check($sformatf("t%0d_data", i), q4, tbl[i].exp_data);
                check($sformatf("t%0d_sat", i), {31'd0, sat4}, {31'd0, tbl[i].exp_sat});
            end
        end

        // ---------------- backpressure ----------------
        for (int j = 0; j < 4; j++) push4(16'h2000);
        rdy_in4 = 1'b0;
        check("bp_first_data", q4, 32'h40000000);
        for (int j = 0; j < 3; j++) push4(16'h1000);
        @(negedge clk);
        v4 = 1'b1;
        d4 = 16'h1000;
        #1;
        check("bp_stall_ready", {31'd0, rdy_out4}, 32'd0);
        repeat (3) @(negedge clk);
        #1;
        check("bp_hold_data", q4, 32'h40000000);
        check("bp_hold_valid", {31'd0, vo4}, 32'd1);
        rdy_in4 = 1'b1;
        #1;
        check("bp_release_ready", {31'd0, rdy_out4}, 32'd1);
        @(posedge clk);
        #1;
        v4 = 1'b0;
        check("bp_b2b_valid", {31'd0, vo4}, 32'd1);
        check("bp_b2b_data", q4, 32'h20000000);
        @(posedge clk);
        #1;
        check("bp_drain_valid", {31'd0, vo4}, 32'd0);

        // ---------------- clear with simultaneous valid ----------------
        push4(16'h2000);
        push4(16'h2000);
        @(negedge clk);
        v4   = 1'b1;
        d4   = 16'h2000;
        clr4 = 1'b1;
        #1;
        check("clr_ready", {31'd0, rdy_out4}, 32'd0);
        @(posedge clk);
        #1;
        v4   = 1'b0;
        clr4 = 1'b0;
        for (int j = 0; j < 4; j++) begin
            push4(16'h1000);
            if (j == 1) check("clr_no_early_valid", {31'd0, vo4}, 32'd0);
        end
        check("clr_valid", {31'd0, vo4}, 32'd1);
        check("clr_data", q4, 32'h20000000);

        // ---------------- asynchronous reset mid-frame ----------------
        for (int j = 0; j < 3; j++) push4(16'h2000);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_data", q4, 32'h0);
        check("arst_valid", {31'd0, vo4}, 32'd0);
        check("arst_sat", {31'd0, sat4}, 32'd0);
        check("arst_data1", q1, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < 4; j++) begin
            push4(16'h2000);
            if (j == 0) check("arst_partial_dropped", {31'd0, vo4}, 32'd0);
        end
        check("arst_valid_after", {31'd0, vo4}, 32'd1);
        check("arst_data_after", q4, 32'h40000000);
        check("arst_sat_after", {31'd0, sat4}, 32'd0);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_fp_extend_accum

`default_nettype wire
